// File: rtl/dda_out_stage_if.sv
// Stream handshake, feedback and overflow-reporting signals for the DDA output stage.
// The slave modport is the stage itself; the master modport is the adder/downstream side.
interface dda_out_stage_if #(
    parameter int unsigned WIDTH = 6
);
    logic [WIDTH-1:0] i_data;
    logic             i_ovf;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_ovf;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_fbk;
    logic             i_ovf_clr;
    logic             o_ovf_sticky;
    logic [7:0]       o_ovf_cnt;

    modport slave (
        input  i_data,
        input  i_ovf,
        input  i_valid,
        input  i_ready,
        input  i_ovf_clr,
        output o_ready,
        output o_data,
        output o_ovf,
        output o_valid,
        output o_fbk,
        output o_ovf_sticky,
        output o_ovf_cnt
    );

    modport master (
        output i_data,
        output i_ovf,
        output i_valid,
        output i_ready,
        output i_ovf_clr,
        input  o_ready,
        input  o_data,
        input  o_ovf,
        input  o_valid,
        input  o_fbk,
        input  o_ovf_sticky,
        input  o_ovf_cnt
    );
endinterface

// File: rtl/dda_out_stage.sv
// Elastic register chain between the DDA adder and downstream, with optional overflow
// saturation, accumulator feedback of the last delivered word and overflow statistics.
module dda_out_stage #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DEPTH  = 2,
    parameter bit          SAT_EN = 1'b0
) (
    input logic            clk,
    input logic            i_rst,
    dda_out_stage_if.slave bus
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] ovf_q;
    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH-1:0] src_ovf;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] ld;

    logic             ready;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] in_data;

    logic [WIDTH-1:0] fbk_q, fbk_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       cnt_q, cnt_d;

    // A stage stalls only when it and every stage after it are occupied and downstream
    // refuses; otherwise the bubble ahead lets the whole run of full stages move together.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        adv       = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            full_tail = full_tail & vld_q[k];
            adv[k]    = vld_q[k] & ~(full_tail & ~bus.i_ready);
        end
    end

    assign ready    = ~vld_q[0] | adv[0];
    assign in_xfer  = bus.i_valid & ready;
    assign out_xfer = adv[DEPTH-1];
    assign in_data  = (SAT_EN && bus.i_ovf) ? {WIDTH{1'b1}} : bus.i_data;

    always_comb begin
        ld          = '0;
        src_ovf     = '0;
        ld[0]       = in_xfer;
        src_data[0] = in_data;
        src_ovf[0]  = bus.i_ovf;
        for (int k = 1; k < int'(DEPTH); k++) begin
            ld[k]       = adv[k-1];
            src_data[k] = data_q[k-1];
            src_ovf[k]  = ovf_q[k-1];
        end
        vld_d = (vld_q & ~adv) | ld;
    end

    // Clear is applied first so a same-cycle overflowed transfer still counts as one.
    always_comb begin
        fbk_d    = out_xfer ? data_q[DEPTH-1] : fbk_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (bus.i_ovf_clr) begin
            sticky_d = 1'b0;
            cnt_d    = 8'd0;
        end
        if (out_xfer && ovf_q[DEPTH-1]) begin
            sticky_d = 1'b1;
            if (cnt_d != 8'hFF) begin
                cnt_d = cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            vld_q    <= '0;
            ovf_q    <= '0;
            fbk_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= 8'd0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            fbk_q    <= fbk_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            // Empty stages keep their old payload; only a loading stage captures.
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (ld[k]) begin
                    data_q[k] <= src_data[k];
                    ovf_q[k]  <= src_ovf[k];
                end
            end
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_valid      = vld_q[DEPTH-1];
    assign bus.o_data       = data_q[DEPTH-1];
    assign bus.o_ovf        = ovf_q[DEPTH-1];
    assign bus.o_fbk        = fbk_q;
    assign bus.o_ovf_sticky = sticky_q;
    assign bus.o_ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_dda_out_stage.sv
// Bench for dda_out_stage: directed vector table and corner sequences on a DEPTH=2 stage,
// then shared random traffic into four configurations checked against a queue-based model.
module tb_dda_out_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst;
    logic [5:0] s_data;
    logic       s_ovf;
    logic       s_valid;
    logic       s_ready;
    logic       s_clr;

    dda_out_stage_if #(.WIDTH(6)) b2 ();
    dda_out_stage_if #(.WIDTH(6)) bs ();
    dda_out_stage_if #(.WIDTH(6)) b1 ();
    dda_out_stage_if #(.WIDTH(6)) b4 ();

    dda_out_stage #(.WIDTH(6), .DEPTH(2), .SAT_EN(1'b0)) u_d2 (.clk(clk), .i_rst(s_rst), .bus(b2));
    dda_out_stage #(.WIDTH(6), .DEPTH(2), .SAT_EN(1'b1)) u_s2 (.clk(clk), .i_rst(s_rst), .bus(bs));
    dda_out_stage #(.WIDTH(6), .DEPTH(1), .SAT_EN(1'b0)) u_d1 (.clk(clk), .i_rst(s_rst), .bus(b1));
    dda_out_stage #(.WIDTH(6), .DEPTH(4), .SAT_EN(1'b1)) u_d4 (.clk(clk), .i_rst(s_rst), .bus(b4));

    assign b2.i_data = s_data;  assign b2.i_ovf = s_ovf;  assign b2.i_valid = s_valid;
    assign b2.i_ready = s_ready; assign b2.i_ovf_clr = s_clr;
    assign bs.i_data = s_data;  assign bs.i_ovf = s_ovf;  assign bs.i_valid = s_valid;
    assign bs.i_ready = s_ready; assign bs.i_ovf_clr = s_clr;
    assign b1.i_data = s_data;  assign b1.i_ovf = s_ovf;  assign b1.i_valid = s_valid;
    assign b1.i_ready = s_ready; assign b1.i_ovf_clr = s_clr;
    assign b4.i_data = s_data;  assign b4.i_ovf = s_ovf;  assign b4.i_valid = s_valid;
    assign b4.i_ready = s_ready; assign b4.i_ovf_clr = s_clr;

    // Index 0: DEPTH2/plain, 1: DEPTH2/sat, 2: DEPTH1/plain, 3: DEPTH4/sat
    logic [3:0]      ov_valid, ov_ready, ov_ovf, ov_sticky;
    logic [3:0][5:0] ov_data, ov_fbk;
    logic [3:0][7:0] ov_cnt;
    assign ov_valid  = {b4.o_valid, b1.o_valid, bs.o_valid, b2.o_valid};
    assign ov_ready  = {b4.o_ready, b1.o_ready, bs.o_ready, b2.o_ready};
    assign ov_ovf    = {b4.o_ovf, b1.o_ovf, bs.o_ovf, b2.o_ovf};
    assign ov_sticky = {b4.o_ovf_sticky, b1.o_ovf_sticky, bs.o_ovf_sticky, b2.o_ovf_sticky};
    assign ov_data   = {b4.o_data, b1.o_data, bs.o_data, b2.o_data};
    assign ov_fbk    = {b4.o_fbk, b1.o_fbk, bs.o_fbk, b2.o_fbk};
    assign ov_cnt    = {b4.o_ovf_cnt, b1.o_ovf_cnt, bs.o_ovf_cnt, b2.o_ovf_cnt};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       valid;
        logic [5:0] data;
        logic       ready;
        logic       e_valid;
        logic       e_ready;
        logic [5:0] e_data;
        logic [5:0] e_fbk;
    } vec_t;
    vec_t tv [13];

    // Model: FIFO of accepted words; the head is visible DEPTH cycles after its acceptance,
    // but never earlier than the cycle after its predecessor left.
    int         dep_t [4];
    bit         sat_t [4];
    logic [5:0] m_data [4][8];
    logic       m_ovf  [4][8];
    int         m_t    [4][8];
    int         m_head [4];
    int         m_cnt  [4];
    int         m_last_dep [4];
    logic [5:0] m_fbk  [4];
    logic       m_sticky [4];
    int         m_ocnt [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_head[k] = 0; m_cnt[k] = 0; m_last_dep[k] = -100;
            m_fbk[k] = 6'h00; m_sticky[k] = 1'b0; m_ocnt[k] = 0;
        end
    endtask

    initial begin
        dep_t = '{2, 2, 1, 4};
        sat_t = '{1'b0, 1'b1, 1'b0, 1'b1};
        tv[0]  = '{1'b1, 6'h05, 1'b1, 1'b0, 1'b1, 6'h00, 6'h00};
        tv[1]  = '{1'b1, 6'h2A, 1'b1, 1'b0, 1'b1, 6'h00, 6'h00};
        tv[2]  = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h05, 6'h00};
        tv[3]  = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h2A, 6'h05};
        tv[4]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 6'h00, 6'h2A};
        tv[5]  = '{1'b1, 6'h01, 1'b0, 1'b0, 1'b1, 6'h00, 6'h2A};
        tv[6]  = '{1'b1, 6'h02, 1'b0, 1'b0, 1'b1, 6'h00, 6'h2A};
        tv[7]  = '{1'b1, 6'h03, 1'b0, 1'b1, 1'b0, 6'h01, 6'h2A};
        tv[8]  = '{1'b1, 6'h03, 1'b0, 1'b1, 1'b0, 6'h01, 6'h2A};
        tv[9]  = '{1'b1, 6'h03, 1'b1, 1'b1, 1'b1, 6'h01, 6'h2A};
        tv[10] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h02, 6'h01};
        tv[11] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h03, 6'h02};
        tv[12] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 6'h00, 6'h03};

        s_rst = 1'b1; s_data = 6'h00; s_ovf = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset dut%0d o_valid", k), 32'(ov_valid[k]), 0);
            chk($sformatf("reset dut%0d o_ready", k), 32'(ov_ready[k]), 1);
            chk($sformatf("reset dut%0d o_data", k), 32'(ov_data[k]), 0);
            chk($sformatf("reset dut%0d o_fbk", k), 32'(ov_fbk[k]), 0);
            chk($sformatf("reset dut%0d sticky", k), 32'(ov_sticky[k]), 0);
            chk($sformatf("reset dut%0d cnt", k), 32'(ov_cnt[k]), 0);
        end

        // Back-to-back stream, then back-pressure fill and drain
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            s_valid = tv[i].valid; s_data = tv[i].data; s_ready = tv[i].ready; s_ovf = 1'b0;
            #1;
            chk($sformatf("vec%0d o_valid", i), 32'(b2.o_valid), 32'(tv[i].e_valid));
            chk($sformatf("vec%0d o_ready", i), 32'(b2.o_ready), 32'(tv[i].e_ready));
            if (tv[i].e_valid) chk($sformatf("vec%0d o_data", i), 32'(b2.o_data), 32'(tv[i].e_data));
            chk($sformatf("vec%0d o_fbk", i), 32'(b2.o_fbk), 32'(tv[i].e_fbk));
        end

        // Saturation of an overflowed word
        @(negedge clk);
        s_valid = 1'b1; s_data = 6'h12; s_ovf = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_ovf = 1'b0;
        @(negedge clk);
        #1;
        chk("sat o_valid", 32'(bs.o_valid), 1);
        chk("sat o_data", 32'(bs.o_data), 32'h3F);
        chk("sat o_ovf", 32'(bs.o_ovf), 1);
        chk("nosat o_data", 32'(b2.o_data), 32'h12);
        chk("nosat o_ovf", 32'(b2.o_ovf), 1);
        @(negedge clk);
        #1;
        chk("sat sticky", 32'(bs.o_ovf_sticky), 1);
        chk("sat cnt", 32'(bs.o_ovf_cnt), 1);
        chk("sat o_fbk", 32'(bs.o_fbk), 32'h3F);
        chk("nosat o_fbk", 32'(b2.o_fbk), 32'h12);

        // Counter clear, saturation at 255, then clear colliding with an overflowed transfer
        @(negedge clk);
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        #1;
        chk("clr sticky", 32'(b2.o_ovf_sticky), 0);
        chk("clr cnt", 32'(b2.o_ovf_cnt), 0);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_ovf = 1'b1; s_data = 6'(i); s_ready = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0; s_ovf = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("cnt saturated", 32'(b2.o_ovf_cnt), 255);
        chk("sat run sticky", 32'(b2.o_ovf_sticky), 1);
        chk("sat run o_fbk", 32'(b2.o_fbk), 32'h3F);
        @(negedge clk);
        s_valid = 1'b1; s_ovf = 1'b1; s_data = 6'h2B;
        @(negedge clk);
        s_valid = 1'b0; s_ovf = 1'b0;
        @(negedge clk);
        s_clr = 1'b1;
        #1;
        chk("clr+xfer o_valid", 32'(b2.o_valid), 1);
        @(negedge clk);
        s_clr = 1'b0;
        #1;
        chk("clr+xfer sticky", 32'(b2.o_ovf_sticky), 1);
        chk("clr+xfer cnt", 32'(b2.o_ovf_cnt), 1);
        chk("clr+xfer o_fbk", 32'(b2.o_fbk), 32'h2B);

        // Reset with a full chain and downstream ready
        @(negedge clk);
        s_ready = 1'b0; s_valid = 1'b1; s_data = 6'h11;
        @(negedge clk);
        s_data = 6'h22;
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("full o_valid", 32'(b2.o_valid), 1);
        chk("full o_ready", 32'(b2.o_ready), 0);
        chk("full o_data", 32'(b2.o_data), 32'h11);
        s_rst = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        chk("rst o_valid", 32'(b2.o_valid), 0);
        chk("rst o_ready", 32'(b2.o_ready), 1);
        chk("rst o_fbk", 32'(b2.o_fbk), 0);
        chk("rst cnt", 32'(b2.o_ovf_cnt), 0);
        chk("rst sticky", 32'(b2.o_ovf_sticky), 0);
        chk("rst o_data", 32'(b2.o_data), 0);

        // Random traffic, all four configurations against the model
        model_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 6'($urandom);
            s_ovf   = ($urandom_range(0, 3) == 0);
            s_ready = 1'($urandom);
            s_clr   = ($urandom_range(0, 31) == 0);
            #1;
            for (int k = 0; k < 4; k++) begin
                int   d, vis, idx;
                logic ev, er;
                d  = dep_t[k];
                ev = 1'b0;
                if (m_cnt[k] > 0) begin
                    vis = m_t[k][m_head[k]] + d;
                    if (m_last_dep[k] + 1 > vis) vis = m_last_dep[k] + 1;
                    ev = (c >= vis);
                end
                er = (m_cnt[k] < d) || s_ready;
                chk($sformatf("rand c%0d dut%0d o_valid", c, k), 32'(ov_valid[k]), 32'(ev));
                chk($sformatf("rand c%0d dut%0d o_ready", c, k), 32'(ov_ready[k]), 32'(er));
                if (ev) begin
                    chk($sformatf("rand c%0d dut%0d o_data", c, k), 32'(ov_data[k]),
                        32'(m_data[k][m_head[k]]));
                    chk($sformatf("rand c%0d dut%0d o_ovf", c, k), 32'(ov_ovf[k]),
                        32'(m_ovf[k][m_head[k]]));
                end
                chk($sformatf("rand c%0d dut%0d o_fbk", c, k), 32'(ov_fbk[k]), 32'(m_fbk[k]));
                chk($sformatf("rand c%0d dut%0d sticky", c, k), 32'(ov_sticky[k]),
                    32'(m_sticky[k]));
                chk($sformatf("rand c%0d dut%0d cnt", c, k), 32'(ov_cnt[k]), m_ocnt[k]);

                if (s_clr) begin
                    m_sticky[k] = 1'b0;
                    m_ocnt[k]   = 0;
                end
                if (ev && s_ready) begin
                    m_fbk[k] = m_data[k][m_head[k]];
                    if (m_ovf[k][m_head[k]]) begin
                        m_sticky[k] = 1'b1;
                        if (m_ocnt[k] < 255) m_ocnt[k]++;
                    end
                    m_head[k]     = (m_head[k] + 1) % 8;
                    m_cnt[k]--;
                    m_last_dep[k] = c;
                end
                if (s_valid && er) begin
                    idx = (m_head[k] + m_cnt[k]) % 8;
                    m_data[k][idx] = (sat_t[k] && s_ovf) ? 6'h3F : s_data;
                    m_ovf[k][idx]  = s_ovf;
                    m_t[k][idx]    = c;
                    m_cnt[k]++;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
